// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline enable/flush sequencer with load-use, branch and memory-wait handling.
// Optional performance counters (stall_cnt, flush_cnt) are built when PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W  = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ID_rs1,
    input  logic [REG_ADDR_W-1:0] ID_rs2,
    input  logic                  ID_use_rs1,
    input  logic                  ID_use_rs2,
    input  logic                  EX_memread,
    input  logic [REG_ADDR_W-1:0] EX_rd,
    input  logic                  EX_branch_taken,
    input  logic                  MEM_memread,
    input  logic                  MEM_memwrite,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  IF_ID_en,
    output logic                  IF_ID_flush,
    output logic                  ID_EX_en,
    output logic                  ID_EX_flush,
    output logic                  EX_MEM_en,
    output logic                  MEM_WB_bubble,
    output logic                  stall,
    output logic                  mem_err
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_busy;
    logic       load_use;
    logic       flush_take;

    // Hazard terms; register 0 never carries a dependency.
    always_comb begin
        mem_busy = (MEM_memread | MEM_memwrite) & ~mem_ready;
        load_use = EX_memread & (EX_rd != '0)
                 & ((ID_use_rs1 & (ID_rs1 == EX_rd))
                 |  (ID_use_rs2 & (ID_rs2 == EX_rd)));
    end

    // Same-cycle pipeline controls, highest-priority condition first.
    always_comb begin
        pc_en         = 1'b1;
        IF_ID_en      = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_en      = 1'b1;
        ID_EX_flush   = 1'b0;
        EX_MEM_en     = 1'b1;
        MEM_WB_bubble = 1'b0;
        stall         = 1'b0;
        mem_err       = 1'b0;
        flush_take    = 1'b0;
        if (rst) begin
            pc_en         = 1'b0;
            IF_ID_en      = 1'b0;
            IF_ID_flush   = 1'b1;
            ID_EX_en      = 1'b0;
            ID_EX_flush   = 1'b1;
            EX_MEM_en     = 1'b0;
            MEM_WB_bubble = 1'b1;
        end else if (state_q == ERR) begin
            pc_en         = 1'b0;
            IF_ID_en      = 1'b0;
            ID_EX_en      = 1'b0;
            EX_MEM_en     = 1'b0;
            MEM_WB_bubble = 1'b1;
            mem_err       = 1'b1;
        end else if (mem_busy) begin
            // Freeze everything; branch/load-use stay visible in the frozen EX.
            pc_en         = 1'b0;
            IF_ID_en      = 1'b0;
            ID_EX_en      = 1'b0;
            EX_MEM_en     = 1'b0;
            MEM_WB_bubble = 1'b1;
            stall         = 1'b1;
        end else if (EX_branch_taken) begin
            // Squashes the ID instruction too, so a coincident load-use is moot.
            IF_ID_flush   = 1'b1;
            ID_EX_flush   = 1'b1;
            flush_take    = 1'b1;
        end else if (load_use) begin
            pc_en         = 1'b0;
            IF_ID_en      = 1'b0;
            ID_EX_flush   = 1'b1;
            stall         = 1'b1;
        end
    end

    // Memory-wait tracking and timeout into the absorbing error state.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (!mem_busy) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == WaitLast) begin
                    state_d    = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters; stall and flush are both 0 in ERR, so they freeze there.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_take && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    if (CNT_W > 0) begin : g_no_perf
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (default build or PERF_CNT_EN with CNT_W=4).
module tb_pipe_hazard_ctrl;

    // Control vector order: pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, bubble, stall, err
    localparam logic [8:0] C_RST  = 9'b001010100;
    localparam logic [8:0] C_ERR  = 9'b000000101;
    localparam logic [8:0] C_BUSY = 9'b000000110;
    localparam logic [8:0] C_BR   = 9'b111111000;
    localparam logic [8:0] C_LU   = 9'b000111010;
    localparam logic [8:0] C_RUN  = 9'b110101000;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ID_rs1, ID_rs2, EX_rd;
    logic       ID_use_rs1, ID_use_rs2, EX_memread, EX_branch_taken;
    logic       MEM_memread, MEM_memwrite, mem_ready;
    logic       pc_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush;
    logic       EX_MEM_en, MEM_WB_bubble, stall, mem_err;
    logic [8:0] ctl;
`ifdef PERF_CNT_EN
    logic [3:0] stall_cnt, flush_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush,
                  EX_MEM_en, MEM_WB_bubble, stall, mem_err};

    pipe_hazard_ctrl #(
        .REG_ADDR_W (3),
        .MEM_TIMEOUT(15),
        .CNT_W      (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ID_rs1         (ID_rs1),
        .ID_rs2         (ID_rs2),
        .ID_use_rs1     (ID_use_rs1),
        .ID_use_rs2     (ID_use_rs2),
        .EX_memread     (EX_memread),
        .EX_rd          (EX_rd),
        .EX_branch_taken(EX_branch_taken),
        .MEM_memread    (MEM_memread),
        .MEM_memwrite   (MEM_memwrite),
        .mem_ready      (mem_ready),
        .pc_en          (pc_en),
        .IF_ID_en       (IF_ID_en),
        .IF_ID_flush    (IF_ID_flush),
        .ID_EX_en       (ID_EX_en),
        .ID_EX_flush    (ID_EX_flush),
        .EX_MEM_en      (EX_MEM_en),
        .MEM_WB_bubble  (MEM_WB_bubble),
        .stall          (stall),
        .mem_err        (mem_err)
`ifdef PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ID_rs1 = 3'd0; ID_rs2 = 3'd0; ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0;
        EX_memread = 1'b0; EX_rd = 3'd0; EX_branch_taken = 1'b0;
        MEM_memread = 1'b0; MEM_memwrite = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic lu_rs2(input logic [2:0] rd);
        EX_memread = 1'b1; EX_rd = rd; ID_rs2 = rd; ID_use_rs2 = 1'b1;
    endtask

    // Controls are combinational: settle, then compare well before the next posedge.
    task automatic cyc(input string tag, input logic [8:0] exp);
        #1;
        chk(tag, 32'(ctl), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk); cyc("rst_idle", C_RST);
        @(negedge clk); lu_rs2(3'd3); mem_ready = 1'b1; cyc("rst_hold", C_RST);

        @(negedge clk); rst = 1'b0; idle(); cyc("run0", C_RUN);
`ifdef PERF_CNT_EN
        chk("cnt_rst_s", 32'(stall_cnt), 32'd0);
        chk("cnt_rst_f", 32'(flush_cnt), 32'd0);
`endif

        @(negedge clk); lu_rs2(3'd3); cyc("lu_rs2", C_LU);
        @(negedge clk); idle(); cyc("lu_after", C_RUN);
        @(negedge clk); lu_rs2(3'd0); cyc("lu_r0", C_RUN);
        @(negedge clk); idle();
        EX_memread = 1'b1; EX_rd = 3'd5; ID_rs1 = 3'd5; ID_use_rs1 = 1'b1;
        cyc("lu_rs1", C_LU);
        @(negedge clk); ID_use_rs1 = 1'b0; cyc("lu_nouse", C_RUN);

        @(negedge clk); idle(); lu_rs2(3'd2); EX_branch_taken = 1'b1;
        cyc("br_lu", C_BR);
`ifdef PERF_CNT_EN
        chk("flush_pre", 32'(flush_cnt), 32'd0);
`endif
        @(negedge clk); idle(); cyc("br_after", C_RUN);
`ifdef PERF_CNT_EN
        chk("flush_post", 32'(flush_cnt), 32'd1);
        chk("stall_two", 32'(stall_cnt), 32'd2);
`endif

        for (int i = 0; i < 4; i++) begin
            @(negedge clk); MEM_memread = 1'b1; mem_ready = 1'b0;
            EX_branch_taken = 1'b1;
            cyc($sformatf("wait%0d", i), C_BUSY);
        end
        @(negedge clk); mem_ready = 1'b1; cyc("wait_rdy_br", C_BR);
        @(negedge clk); idle(); cyc("wait_done", C_RUN);
`ifdef PERF_CNT_EN
        chk("stall_six", 32'(stall_cnt), 32'd6);
        chk("flush_two", 32'(flush_cnt), 32'd2);
`endif

        @(negedge clk); MEM_memwrite = 1'b1; mem_ready = 1'b1; cyc("zero_wait", C_RUN);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk); idle(); lu_rs2(3'd7);
            cyc($sformatf("sat_lu%0d", i), C_LU);
        end
        @(negedge clk); idle(); cyc("sat_end", C_RUN);
`ifdef PERF_CNT_EN
        chk("stall_sat", 32'(stall_cnt), 32'd15);
`endif

        // Partial wait, then reset: the later timeout must count from scratch.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); MEM_memread = 1'b1; mem_ready = 1'b0;
            cyc($sformatf("pre%0d", i), C_BUSY);
        end
        @(negedge clk); rst = 1'b1; cyc("midwait_rst", C_RST);
        @(negedge clk); rst = 1'b0; idle(); cyc("midwait_rel", C_RUN);

        for (int i = 1; i <= 15; i++) begin
            @(negedge clk); MEM_memwrite = 1'b1; mem_ready = 1'b0;
            cyc($sformatf("to_busy%0d", i), C_BUSY);
        end
        @(negedge clk); cyc("to_err16", C_ERR);
        @(negedge clk); idle(); EX_branch_taken = 1'b1; cyc("err_hold", C_ERR);
`ifdef PERF_CNT_EN
        chk("stall_err", 32'(stall_cnt), 32'd15);
        chk("flush_err", 32'(flush_cnt), 32'd0);
`endif

        @(negedge clk); rst = 1'b1; cyc("err_rst", C_RST);
        @(negedge clk); rst = 1'b0; idle(); cyc("err_clr", C_RUN);
        @(negedge clk); MEM_memread = 1'b1; mem_ready = 1'b0; cyc("post_busy", C_BUSY);
        @(negedge clk); mem_ready = 1'b1; cyc("post_rdy", C_RUN);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage CPU.
- Drives the enable and flush/bubble controls of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
- Resolves three conditions: load-use hazards, taken-branch flushes, and variable-latency data-memory waits.
- Contains a memory-wait timeout that latches a fatal error and halts the pipeline.

Parameters:
- REG_ADDR_W, 3, register-address width (matches rd/rs fields).
- MEM_TIMEOUT, 15, consecutive busy-memory cycles before fatal error; legal range 2..255.
- CNT_W, 16, performance-counter width (used only with PERF_CNT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ID_rs1  in  REG_ADDR_W  source reg 1 of the instruction in ID.
- ID_rs2  in  REG_ADDR_W  source reg 2 of the instruction in ID.
- ID_use_rs1  in  1  ID instruction reads rs1.
- ID_use_rs2  in  1  ID instruction reads rs2.
- EX_memread  in  1  EX instruction is a load.
- EX_rd  in  REG_ADDR_W  EX destination register.
- EX_branch_taken  in  1  branch resolved taken in EX.
- MEM_memread  in  1  MEM-stage load.
- MEM_memwrite  in  1  MEM-stage store.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- IF_ID_en  out  1  IF_ID register enable.
- IF_ID_flush  out  1  IF_ID clear to NOP.
- ID_EX_en  out  1  ID_EX register enable.
- ID_EX_flush  out  1  ID_EX clear to bubble (all control bits 0).
- EX_MEM_en  out  1  EX_MEM register enable.
- MEM_WB_bubble  out  1  MEM_WB loads a bubble (regwrite=0).
- stall  out  1  pc_en is 0 for a reason other than reset.
- mem_err  out  1  sticky memory-timeout error.

Behaviour:
- Reset: the clock and reset are as already decided (one clock `clk`; asynchronous, active-high reset `rst`).
  - While rst=1: all _en outputs=0, IF_ID_flush=ID_EX_flush=MEM_WB_bubble=1, stall=0, mem_err=0.
  - Reset clears state to RUN and wait_cnt to 0.
  - Reset mid-wait or in ERR aborts immediately, with no residual state.
- Derived terms:
  - mem_busy = (MEM_memread | MEM_memwrite) & ~mem_ready.
  - load_use = EX_memread & (EX_rd != 0) & ((ID_use_rs1 & ID_rs1==EX_rd) | (ID_use_rs2 & ID_rs2==EX_rd)).
  - r0 is hardwired zero, so it never creates a hazard.
- Controls are combinational (same-cycle) from state and inputs. Priority is highest first:
  1. state ERR: all _en=0, flushes=0, MEM_WB_bubble=1, stall=0, mem_err=1.
  2. mem_busy: pc_en=IF_ID_en=ID_EX_en=EX_MEM_en=0, MEM_WB_bubble=1, flushes=0, stall=1.
     - EX_branch_taken and load_use are ignored this cycle. They persist because EX is frozen, and are acted on once the memory is ready.
  3. EX_branch_taken: all _en=1, IF_ID_flush=1, ID_EX_flush=1, stall=0.
     - A branch plus load_use in the same cycle is resolved as a flush only; the hazarding ID instruction is squashed.
  4. load_use: pc_en=0, IF_ID_en=0, ID_EX_en=1, ID_EX_flush=1, EX_MEM_en=1, stall=1.
     - This is exactly one bubble, because the load leaves EX on the next edge.
  5. otherwise: all _en=1, flushes=0, MEM_WB_bubble=0, stall=0.
- FSM, updated at posedge clk. States: RUN, MEM_WAIT, ERR.
  - RUN: if mem_busy, set wait_cnt=1 and go to MEM_WAIT (wait_cnt=1 if MEM_TIMEOUT would be reached is not possible since MEM_TIMEOUT>=2).
  - MEM_WAIT: if mem_ready, or no memory op present, set wait_cnt=0 and go to RUN.
  - MEM_WAIT: else if wait_cnt==MEM_TIMEOUT-1, go to ERR.
  - MEM_WAIT: else wait_cnt++.
  - ERR: absorbing; exits only by reset.
- Consequence of the timeout rule: the MEM_TIMEOUT-th consecutive busy cycle is the last frozen cycle, and ERR asserts on the following cycle.
- A mem_ready in the same cycle a request appears costs zero stall cycles.
- wait_cnt is 8 bits wide.

Optional Feature:
- Macro: PERF_CNT_EN.
- When defined, two extra outputs are added:
  - stall_cnt [CNT_W-1:0]: increments each cycle stall=1.
  - flush_cnt [CNT_W-1:0]: increments each cycle priority case 3 is taken.
- Both counters reset to 0, saturate at all-ones (no wrap), and are frozen in ERR.
- When undefined, neither the ports nor the logic exist; the rest of the behaviour is identical.

Test Plan:
- Reset then idle inputs:
  - During rst, all _en=0 and flushes=1.
  - First cycle after rst, all _en=1, flushes=0, stall=0.
- Load-use: EX_memread=1, EX_rd=3, ID_rs2=3, ID_use_rs2=1 for one cycle.
  - Response: pc_en=0, IF_ID_en=0, ID_EX_flush=1, stall=1 for exactly 1 cycle.
  - Repeat with EX_rd=0: no stall.
- Branch: EX_branch_taken=1 together with load_use.
  - Response: IF_ID_flush=ID_EX_flush=1, pc_en=1, stall=0.
  - With PERF_CNT_EN: flush_cnt goes 0→1.
- Memory wait: MEM_memread=1, mem_ready=0 for 4 cycles, then 1.
  - Response: 4 frozen cycles with EX_MEM_en=0 and MEM_WB_bubble=1, then all enables resume.
  - A branch held during the wait flushes on the ready cycle.
- Timeout: MEM_memwrite=1, mem_ready=0 held with MEM_TIMEOUT=15.
  - Response: mem_err=1 starting cycle 16 and held.
  - Asserting rst mid-ERR clears mem_err and state.
- Counter saturation (PERF_CNT_EN, CNT_W=4): hold load_use stalls for 20 cycles.
  - Response: stall_cnt saturates at 15.
